ex_stage: RTL and testbench



---
 rtl/ex_stage.sv | 192 +++++++++++++++++++
 tb/tb_ex_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage fed by the ID/EX latch.
// Single-cycle logic/arith/compare ops register their result toward MEM one
// edge after being presented. Shifts step one bit per cycle in a small
// IDLE/BUSY engine and hold the pipeline through stallreq_o while they run.
// Optional macro EX_MUL_EN adds a 32-step unsigned shift-add multiplier;
// without it MUL completes in one cycle as a non-writing no-op.
module ex_stage #(
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 6
) (
  input  logic        dclk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] regdata1_i,
  input  logic [31:0] regdata2_i,
  input  logic        wreg_i,
  input  logic [4:0]  waddr_i,
  output logic        wreg_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o
);

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_ARITH = 3'b010;
  localparam logic [2:0] SEL_SHIFT = 3'b011;
  localparam logic [2:0] SEL_MUL   = 3'b100;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_SLT  = 8'h03;
  localparam logic [7:0] OP_SLTU = 8'h04;
  localparam logic [7:0] OP_AND  = 8'h05;
  localparam logic [7:0] OP_OR   = 8'h06;
  localparam logic [7:0] OP_XOR  = 8'h07;
  localparam logic [7:0] OP_SLL  = 8'h08;
  localparam logic [7:0] OP_SRL  = 8'h09;
  localparam logic [7:0] OP_SRA  = 8'h0A;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_op;
  logic [31:0]      r_val;
  logic             r_wreg;
  logic [4:0]       r_waddr;

  logic             w_isShift;
  logic             w_isMul;
  logic             w_shamtNonZero;
  logic             w_startMulti;
  logic [CNT_W-1:0] w_loadCnt;
  logic             w_valid;
  logic [31:0]      w_result;
  logic [31:0]      w_shiftNext;
  logic [31:0]      w_valNext;
  logic [31:0]      w_stepResult;

  assign w_isShift = (alusel_i == SEL_SHIFT) &&
                     ((aluop_i == OP_SLL) || (aluop_i == OP_SRL) || (aluop_i == OP_SRA));
  assign w_shamtNonZero = (regdata2_i[SHIFT_W-1:0] != '0);
  assign w_startMulti   = (w_isShift && w_shamtNonZero) || w_isMul;
  assign w_loadCnt      = w_isMul ? CNT_W'(32) : CNT_W'(regdata2_i[SHIFT_W-1:0]);

  // Stall upstream while a multi-cycle op is being accepted or still has more than one step left
  assign stallreq_o = !rst &&
                      (((r_state == S_IDLE) && w_startMulti) ||
                       ((r_state == S_BUSY) && (r_cnt > CNT_W'(1))));

  // Single-cycle result; unknown ops inside a class and NOP produce an invalid (non-writing) zero
  always_comb begin
    w_valid  = 1'b0;
    w_result = '0;
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_AND: begin w_valid = 1'b1; w_result = regdata1_i & regdata2_i; end
          OP_OR:  begin w_valid = 1'b1; w_result = regdata1_i | regdata2_i; end
          OP_XOR: begin w_valid = 1'b1; w_result = regdata1_i ^ regdata2_i; end
          default: ;
        endcase
      end
      SEL_ARITH: begin
        case (aluop_i)
          OP_ADD:  begin w_valid = 1'b1; w_result = regdata1_i + regdata2_i; end
          OP_SUB:  begin w_valid = 1'b1; w_result = regdata1_i - regdata2_i; end
          OP_SLT:  begin w_valid = 1'b1; w_result = {31'd0, $signed(regdata1_i) < $signed(regdata2_i)}; end
          OP_SLTU: begin w_valid = 1'b1; w_result = {31'd0, regdata1_i < regdata2_i}; end
          default: ;
        endcase
      end
      SEL_SHIFT: begin
        if (w_isShift) begin
          w_valid  = 1'b1;
          w_result = regdata1_i;
        end
      end
      SEL_MUL: w_valid = 1'b0;
      SEL_NOP: w_valid = 1'b0;
      default: w_valid = 1'b0;
    endcase
  end

  // One-bit shift step of the value held in the iterative engine
  always_comb begin
    w_shiftNext = r_val;
    case (r_op)
      OP_SLL:  w_shiftNext = {r_val[30:0], 1'b0};
      OP_SRL:  w_shiftNext = {1'b0, r_val[31:1]};
      OP_SRA:  w_shiftNext = {r_val[31], r_val[31:1]};
      default: w_shiftNext = r_val;
    endcase
  end

`ifdef EX_MUL_EN
  localparam logic [7:0] OP_MUL = 8'h0B;

  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [31:0] w_accNext;
  logic        w_busyIsMul;

  assign w_isMul      = (alusel_i == SEL_MUL) && (aluop_i == OP_MUL);
  assign w_busyIsMul  = (r_op == OP_MUL);
  assign w_accNext    = r_acc + (r_mplier[0] ? r_val : 32'd0);
  assign w_stepResult = w_busyIsMul ? w_accNext : w_shiftNext;
  assign w_valNext    = w_busyIsMul ? {r_val[30:0], 1'b0} : w_shiftNext;

  // Multiplier and accumulator for the shift-add multiply; r_val doubles as the shifting multiplicand
  always_ff @(posedge dclk) begin
    if (rst) begin
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (r_state == S_IDLE) begin
      r_mplier <= regdata2_i;
      r_acc    <= '0;
    end else begin
      r_mplier <= {1'b0, r_mplier[31:1]};
      r_acc    <= w_accNext;
    end
  end
`else
  assign w_isMul      = 1'b0;
  assign w_stepResult = w_shiftNext;
  assign w_valNext    = w_shiftNext;
`endif

  // Main sequencer: register single-cycle results, or run the iterative engine and emit bubbles until done
  always_ff @(posedge dclk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_val   <= '0;
      r_wreg  <= 1'b0;
      r_waddr <= '0;
      wreg_o  <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_startMulti) begin
        r_state <= S_BUSY;
        r_cnt   <= w_loadCnt;
        r_op    <= aluop_i;
        r_val   <= regdata1_i;
        r_wreg  <= wreg_i && (waddr_i != 5'd0);
        r_waddr <= waddr_i;
        wreg_o  <= 1'b0;
      end else begin
        wreg_o  <= w_valid && wreg_i && (waddr_i != 5'd0);
        waddr_o <= waddr_i;
        wdata_o <= w_result;
      end
    end else begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_val <= w_valNext;
      if (r_cnt == CNT_W'(1)) begin
        r_state <= S_IDLE;
        wreg_o  <= r_wreg;
        waddr_o <= r_waddr;
        wdata_o <= w_stepResult;
      end else begin
        wreg_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors for ex_stage checked against an
// instruction-level model; honours EX_MUL_EN the same way the design does.
module tb_ex_stage;

  logic        dclk;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] regdata1_i;
  logic [31:0] regdata2_i;
  logic        wreg_i;
  logic [4:0]  waddr_i;
  logic        wreg_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit        full;
    bit        wreg;
    bit [4:0]  waddr;
    bit [31:0] wdata;
  } outExp_t;

  outExp_t outQ[$];
  bit      stallQ[$];

  ex_stage dut (
    .dclk       (dclk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .regdata1_i (regdata1_i),
    .regdata2_i (regdata2_i),
    .wreg_i     (wreg_i),
    .waddr_i    (waddr_i),
    .wreg_o     (wreg_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .stallreq_o (stallreq_o)
  );

  // Free-running clock
  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Instruction-level reference: what the op computes, whether it writes, and its step count
  task automatic modelOp(input logic [2:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         output bit valid, output logic [31:0] res, output int n);
    valid = 1'b0;
    res   = 32'd0;
    n     = 0;
    case (sel)
      3'd1: case (op)
              8'h05: begin valid = 1; res = a & b; end
              8'h06: begin valid = 1; res = a | b; end
              8'h07: begin valid = 1; res = a ^ b; end
              default: ;
            endcase
      3'd2: case (op)
              8'h01: begin valid = 1; res = a + b; end
              8'h02: begin valid = 1; res = a - b; end
              8'h03: begin valid = 1; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
              8'h04: begin valid = 1; res = (a < b) ? 32'd1 : 32'd0; end
              default: ;
            endcase
      3'd3: case (op)
              8'h08: begin valid = 1; n = int'(b[4:0]); res = a << b[4:0]; end
              8'h09: begin valid = 1; n = int'(b[4:0]); res = a >> b[4:0]; end
              8'h0A: begin valid = 1; n = int'(b[4:0]); res = $unsigned($signed(a) >>> b[4:0]); end
              default: ;
            endcase
`ifdef EX_MUL_EN
      3'd4: if (op == 8'h0B) begin
              longint unsigned p;
              p = longint'(a) * longint'(b);
              valid = 1; n = 32; res = p[31:0];
            end
`endif
      default: ;
    endcase
  endtask

  // Present one instruction, queue per-cycle stall and per-edge output expectations, hold it until done
  task automatic applyStimulus(input string name, input logic [2:0] sel, input logic [7:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic we, input logic [4:0] wa,
                               input logic [31:0] pinData, input logic pinWreg);
    bit          valid;
    logic [31:0] res;
    int          n;
    int          lat;
    bit          expWreg;
    outExp_t     e;
    alusel_i   = sel;
    aluop_i    = op;
    regdata1_i = a;
    regdata2_i = b;
    wreg_i     = we;
    waddr_i    = wa;
    modelOp(sel, op, a, b, valid, res, n);
    expWreg = valid && we && (wa != 5'd0);
    checkOutput({name, "_model_data"}, res, pinData);
    checkOutput({name, "_model_wreg"}, {31'd0, expWreg}, {31'd0, pinWreg});
    lat = (n > 0) ? n + 1 : 1;
    for (int c = 0; c < lat; c++) stallQ.push_back(c < n);
    for (int c = 0; c < lat - 1; c++) begin
      e.full = 0; e.wreg = 0; e.waddr = '0; e.wdata = '0;
      outQ.push_back(e);
    end
    e.full = 1; e.wreg = expWreg; e.waddr = wa; e.wdata = res;
    outQ.push_back(e);
    repeat (lat) begin
      @(posedge dclk);
      #1;
    end
  endtask

  // Compare process: stall for the current cycle, registered outputs for the latest edge
  always @(negedge dclk) begin
    if (stallQ.size() > 0) begin
      bit s;
      s = stallQ.pop_front();
      checkOutput("stallreq", {31'd0, stallreq_o}, {31'd0, s});
    end
    if (outQ.size() > 0) begin
      outExp_t e;
      e = outQ.pop_front();
      checkOutput("wreg", {31'd0, wreg_o}, {31'd0, e.wreg});
      if (e.full) begin
        checkOutput("waddr", {27'd0, waddr_o}, {27'd0, e.waddr});
        checkOutput("wdata", wdata_o, e.wdata);
      end
    end
  end

  // Directed sequence: reset mid-shift first, then the model-checked instruction stream
  initial begin
    outExp_t e;
    logic [31:0] mulData;
    logic        mulWreg;
    rst = 1'b1; alusel_i = '0; aluop_i = '0; regdata1_i = '0; regdata2_i = '0; wreg_i = 0; waddr_i = '0;
    repeat (2) @(posedge dclk);
    @(negedge dclk);
    checkOutput("rst_wreg", {31'd0, wreg_o}, 32'd0);
    checkOutput("rst_waddr", {27'd0, waddr_o}, 32'd0);
    checkOutput("rst_wdata", wdata_o, 32'd0);
    checkOutput("rst_stall", {31'd0, stallreq_o}, 32'd0);

    @(posedge dclk); #1;
    rst = 1'b0;
    alusel_i = 3'd3; aluop_i = 8'h08; regdata1_i = 32'd1; regdata2_i = 32'd10; wreg_i = 1; waddr_i = 5'd3;
    @(negedge dclk);
    checkOutput("sll10_stall_accept", {31'd0, stallreq_o}, 32'd1);
    repeat (5) @(posedge dclk);
    @(negedge dclk);
    checkOutput("sll10_stall_mid", {31'd0, stallreq_o}, 32'd1);
    checkOutput("sll10_bubble", {31'd0, wreg_o}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_stall", {31'd0, stallreq_o}, 32'd0);
    repeat (2) @(posedge dclk);
    @(negedge dclk);
    checkOutput("midrst_wreg", {31'd0, wreg_o}, 32'd0);
    checkOutput("midrst_wdata", wdata_o, 32'd0);
    checkOutput("midrst_stall2", {31'd0, stallreq_o}, 32'd0);
    @(posedge dclk); #1;
    rst = 1'b0;

    e.full = 1; e.wreg = 0; e.waddr = '0; e.wdata = '0;
    outQ.push_back(e);

    applyStimulus("add_wrap",  3'd2, 8'h01, 32'hFFFFFFFF, 32'd2, 1, 5'd5, 32'd1, 1);
    applyStimulus("slt",       3'd2, 8'h03, 32'hFFFFFFFF, 32'd1, 1, 5'd6, 32'd1, 1);
    applyStimulus("sltu",      3'd2, 8'h04, 32'hFFFFFFFF, 32'd1, 1, 5'd7, 32'd0, 1);
    applyStimulus("sra4",      3'd3, 8'h0A, 32'h80000000, 32'd4, 1, 5'd8, 32'hF8000000, 1);
    applyStimulus("sll0",      3'd3, 8'h08, 32'h00001234, 32'd0, 1, 5'd9, 32'h00001234, 1);
    applyStimulus("srl1",      3'd3, 8'h09, 32'h00000080, 32'd1, 1, 5'd10, 32'h00000040, 1);
    applyStimulus("add_b2b",   3'd2, 8'h01, 32'd3, 32'd4, 1, 5'd11, 32'd7, 1);
    applyStimulus("add_x0",    3'd2, 8'h01, 32'd2, 32'd3, 1, 5'd0, 32'd5, 0);
`ifdef EX_MUL_EN
    mulData = 32'h00030000; mulWreg = 1'b1;
`else
    mulData = 32'h00000000; mulWreg = 1'b0;
`endif
    applyStimulus("mul",       3'd4, 8'h0B, 32'h00010000, 32'h00030003, 1, 5'd12, mulData, mulWreg);
    applyStimulus("sub",       3'd2, 8'h02, 32'd5, 32'd7, 1, 5'd13, 32'hFFFFFFFE, 1);
    applyStimulus("and",       3'd1, 8'h05, 32'hF0F0F0F0, 32'hFF00FF00, 1, 5'd14, 32'hF000F000, 1);
    applyStimulus("or",        3'd1, 8'h06, 32'hF0F0F0F0, 32'h0F000000, 1, 5'd15, 32'hFFF0F0F0, 1);
    applyStimulus("xor",       3'd1, 8'h07, 32'hFFFF0000, 32'hFF00FF00, 1, 5'd16, 32'h00FFFF00, 1);
    applyStimulus("logic_bad", 3'd1, 8'h01, 32'h12345678, 32'h1, 1, 5'd17, 32'd0, 0);
    applyStimulus("nop",       3'd0, 8'h00, 32'h12345678, 32'h1, 1, 5'd18, 32'd0, 0);
    applyStimulus("sll31",     3'd3, 8'h08, 32'h00000001, 32'd31, 1, 5'd19, 32'h80000000, 1);
    applyStimulus("sra3_pos",  3'd3, 8'h0A, 32'h7FFFFFF0, 32'hFFFFFFE3, 1, 5'd20, 32'h0FFFFFFE, 1);
    applyStimulus("add_nowr",  3'd2, 8'h01, 32'd10, 32'd20, 0, 5'd21, 32'd30, 0);
    applyStimulus("tail_nop",  3'd0, 8'h00, 32'd0, 32'd0, 0, 5'd0, 32'd0, 0);

    repeat (2) @(posedge dclk);
    #1;
    checkOutput("queues_drained", outQ.size() + stallQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
